// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared states, error codes and PS/2 protocol bytes for ps2_cmd_ctrl.
// Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_TX  = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
`ifdef PS2_CMD_INIT_EN
    ,
    S_INIT     = 3'd6,
    S_INIT_BAT = 3'd7
`endif
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'd0,
    ERR_RETRY   = 2'd1,
    ERR_KBD     = 2'd2,
    ERR_RSVD    = 2'd3
  } ps2_err_e;

  localparam logic       PH_CMD        = 1'b0;
  localparam logic       PH_ARG        = 1'b1;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ERR       = 8'hFC;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/ps2_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cmd_ctrl_if
// Brief    : Command, transmit, receive and status signals of ps2_cmd_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface ps2_cmd_ctrl_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] cmd_arg;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [7:0] rx_code;
  logic       rx_code_new;
  logic       rx_valid;
  logic [7:0] scan_code;
  logic       scan_new;
  logic       cmd_done;
  logic       cmd_err;
  logic [1:0] err_code;

  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, tx_done,
           rx_code, rx_code_new, rx_valid,
    output cmd_ready, tx_start, tx_data, scan_code, scan_new,
           cmd_done, cmd_err, err_code
  );

  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, tx_done,
           rx_code, rx_code_new, rx_valid,
    input  cmd_ready, tx_start, tx_data, scan_code, scan_new,
           cmd_done, cmd_err, err_code
  );

endinterface
`default_nettype wire

// File: rtl/ps2_rsp_timer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rsp_timer
// Brief    : Clearable saturating response timer with an expiry flag.
// Revision : 1.0  initial release
// ============================================================================
module ps2_rsp_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Raised on the cycle the count lands on the limit, so the waiting state
  // is occupied for exactly TIMEOUT_CYCLES cycles before it gives up.
  assign expired_o = en_i && !clr_i && (cnt_d == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cmd_ctrl
// Brief    : PS/2 host command sequencer with ACK/resend/timeout handling.
//            Define PS2_CMD_INIT_EN to issue a keyboard reset (0xFF) after rst.
// Revision : 1.0  initial release
// ============================================================================
module ps2_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input logic           clk,
  input logic           rst,
  ps2_cmd_ctrl_if.slave bus
);

  localparam int            RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  logic [2:0]    state_q, state_d;
  logic          phase_q, phase_d;
  logic          has_arg_q, has_arg_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    arg_q, arg_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    err_q, err_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_new_q, scan_new_d;
`ifdef PS2_CMD_INIT_EN
  logic          init_q, init_d;
`endif

  logic w_rx_ok, w_is_ack, w_is_resend, w_is_kerr;
  logic w_consume, w_tmr_clr, w_tmr_en, w_tmr_exp;

  assign w_rx_ok     = bus.rx_code_new & bus.rx_valid;
  assign w_is_ack    = w_rx_ok && (bus.rx_code == PS2_ACK);
  assign w_is_resend = w_rx_ok && (bus.rx_code == PS2_RESEND);
  assign w_is_kerr   = w_rx_ok && (bus.rx_code == PS2_ERR);

`ifdef PS2_CMD_INIT_EN
  assign w_tmr_en = (state_q == S_WAIT_RSP) || (state_q == S_INIT_BAT);
`else
  assign w_tmr_en = (state_q == S_WAIT_RSP);
`endif

  ps2_rsp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (w_tmr_clr),
    .en_i     (w_tmr_en),
    .expired_o(w_tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    has_arg_d = has_arg_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    retry_d   = retry_q;
    err_d     = err_q;
    w_consume = 1'b0;
    w_tmr_clr = 1'b0;
`ifdef PS2_CMD_INIT_EN
    init_d    = init_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d     = bus.cmd_byte;
          arg_d     = bus.cmd_arg;
          has_arg_d = bus.cmd_has_arg;
          phase_d   = PH_CMD;
          retry_d   = '0;
          err_d     = ERR_TIMEOUT;
          state_d   = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (bus.tx_done) begin
          w_tmr_clr = 1'b1;
          state_d   = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        // Responses are checked before expiry so a same-cycle reply wins.
        if (w_is_ack) begin
          w_consume = 1'b1;
          if ((phase_q == PH_CMD) && has_arg_q) begin
            phase_d = PH_ARG;
            retry_d = '0;
            state_d = S_SEND;
          end
`ifdef PS2_CMD_INIT_EN
          else if (init_q) begin
            w_tmr_clr = 1'b1;
            state_d   = S_INIT_BAT;
          end
`endif
          else begin
            state_d = S_DONE;
          end
        end else if (w_is_resend) begin
          w_consume = 1'b1;
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RW'(1);
            state_d = S_SEND;
          end else begin
            err_d   = ERR_RETRY;
            state_d = S_ERR;
          end
        end else if (w_is_kerr) begin
          w_consume = 1'b1;
          err_d     = ERR_KBD;
          state_d   = S_ERR;
        end else if (w_tmr_exp) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
`ifdef PS2_CMD_INIT_EN
        init_d  = 1'b0;
`endif
      end
`ifdef PS2_CMD_INIT_EN
      S_INIT: begin
        cmd_d     = PS2_CMD_RESET;
        has_arg_d = 1'b0;
        phase_d   = PH_CMD;
        retry_d   = '0;
        err_d     = ERR_TIMEOUT;
        state_d   = S_SEND;
      end
      S_INIT_BAT: begin
        if (w_rx_ok && (bus.rx_code == PS2_BAT_OK)) begin
          w_consume = 1'b1;
          init_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (w_is_kerr) begin
          w_consume = 1'b1;
          err_d     = ERR_KBD;
          state_d   = S_ERR;
        end else if (w_tmr_exp) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign scan_new_d  = w_rx_ok && !w_consume;
  assign scan_code_d = scan_new_d ? bus.rx_code : scan_code_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef PS2_CMD_INIT_EN
      state_q     <= S_INIT;
      init_q      <= 1'b1;
`else
      state_q     <= S_IDLE;
`endif
      phase_q     <= PH_CMD;
      has_arg_q   <= 1'b0;
      cmd_q       <= 8'h00;
      arg_q       <= 8'h00;
      retry_q     <= '0;
      err_q       <= ERR_TIMEOUT;
      scan_code_q <= 8'h00;
      scan_new_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
`ifdef PS2_CMD_INIT_EN
      init_q      <= init_d;
`endif
      phase_q     <= phase_d;
      has_arg_q   <= has_arg_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      scan_code_q <= scan_code_d;
      scan_new_q  <= scan_new_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.tx_start  = (state_q == S_SEND);
  assign bus.tx_data   = (phase_q == PH_ARG) ? arg_q : cmd_q;
  assign bus.scan_code = scan_code_q;
  assign bus.scan_new  = scan_new_q;
  assign bus.cmd_done  = (state_q == S_DONE);
  assign bus.cmd_err   = (state_q == S_ERR);
  assign bus.err_code  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_cmd_ctrl
// Brief    : Scoreboard bench for ps2_cmd_ctrl (TIMEOUT_CYCLES=50, MAX_RETRY=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_cmd_ctrl;

  localparam int TMO     = 50;
  localparam int MAXR    = 2;
  localparam int IT_NONE = -1;
  localparam int JV      = 32'h200;  // valid non-response byte in the script
  localparam int JI      = 32'h400;  // byte carried with rx_valid low

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    longint     cyc;
  } end_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc   = 0;
  int     n_pass = 0;
  int     n_total = 0;
  int     end_cnt = 0;
  bit     busy = 1'b0;
  int     td_delay = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_scan[$];
  end_t       exp_end[$];
  int         script[$];
  end_t       m_e;

  ps2_cmd_ctrl_if bus ();

  ps2_cmd_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_start) begin
        if (exp_tx.size() == 0) begin
          n_total++;
          $display("FAIL tx_start: got unexpected pulse data=%02h, expected none", bus.tx_data);
        end else chk("tx_data", bus.tx_data, exp_tx.pop_front());
      end
      if (bus.scan_new) begin
        if (exp_scan.size() == 0) begin
          n_total++;
          $display("FAIL scan_new: got unexpected code=%02h, expected none", bus.scan_code);
        end else chk("scan_code", bus.scan_code, exp_scan.pop_front());
      end
      if (bus.cmd_done || bus.cmd_err) begin
        if (exp_end.size() == 0) begin
          n_total++;
          $display("FAIL cmd_end: got unexpected done=%0b err=%0b, expected none", bus.cmd_done, bus.cmd_err);
        end else begin
          m_e = exp_end.pop_front();
          chk("end_is_err", bus.cmd_err, m_e.is_err);
          chk("end_is_done", bus.cmd_done, !m_e.is_err);
          if (m_e.is_err) chk("err_code", bus.err_code, m_e.code);
          chk("end_cycle", cyc, m_e.cyc);
        end
        end_cnt++;
      end else if (busy) begin
        chk("ready_low_busy", bus.cmd_ready, 0);
      end
    end
  end

  task automatic check_reset(string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_tx_start"},  bus.tx_start, 0);
    chk({tag, "_tx_data"},   bus.tx_data, 0);
    chk({tag, "_scan_code"}, bus.scan_code, 0);
    chk({tag, "_scan_new"},  bus.scan_new, 0);
    chk({tag, "_cmd_done"},  bus.cmd_done, 0);
    chk({tag, "_cmd_err"},   bus.cmd_err, 0);
    chk({tag, "_err_code"},  bus.err_code, 0);
  endtask

  task automatic send_rx(input logic [7:0] code, input bit v, output longint stamp);
    @(posedge clk); #1;
    bus.rx_code     = code;
    bus.rx_valid    = v;
    bus.rx_code_new = 1'b1;
    stamp           = cyc;
    @(posedge clk); #1;
    bus.rx_code_new = 1'b0;
    bus.rx_valid    = 1'($urandom);
    bus.rx_code     = 8'($urandom);
  endtask

  function automatic int pick_item(int njunk);
    int          r;
    logic [7:0]  b;
    r = int'($urandom_range(0, 99));
    if (njunk < 3 && r < 20) begin
      do b = 8'($urandom); while (b == 8'hFA || b == 8'hFE || b == 8'hFC);
      return JV | int'(b);
    end
    if (njunk < 3 && r < 30) return JI | int'($urandom_range(0, 255));
    r = int'($urandom_range(0, 99));
    if (r < 60) return 32'hFA;
    if (r < 82) return 32'hFE;
    if (r < 90) return 32'hFC;
    return IT_NONE;
  endfunction

  task automatic wait_tx_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept(input logic [7:0] c, input bit ha, input logic [7:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("ready_before_accept", ok, 1);
    if (ok) begin
      bus.cmd_valid   = 1'b1;
      bus.cmd_byte    = c;
      bus.cmd_has_arg = ha;
      bus.cmd_arg     = a;
      exp_tx.push_back(c);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      busy          = 1'b1;
    end
  endtask

  // Reference model: each transmitted byte gets a reply; ACK advances to the
  // next byte, RESEND repeats it up to MAXR times, anything else ends it.
  task automatic run_cmd(input logic [7:0] c, input bit ha, input logic [7:0] a);
    logic [7:0] bytes[2];
    int         n, idx, retries, item, njunk, d, start_cnt;
    bit         fin, ok;
    longint     td, st;
    end_t       e;
    bytes[0] = c;
    bytes[1] = a;
    n        = ha ? 2 : 1;
    idx      = 0;
    retries  = 0;
    fin      = 1'b0;
    start_cnt = end_cnt;
    accept(c, ha, a, ok);
    if (!ok) return;
    while (!fin) begin
      wait_tx_start(ok);
      if (!ok) begin
        n_total++;
        $display("FAIL tx_start_wait: got no pulse in 40 cycles, expected byte %02h", bytes[idx]);
        break;
      end
      d = (td_delay > 0) ? td_delay : int'($urandom_range(1, 12));
      for (int i = 0; i < d; i++) begin
        @(posedge clk); #1;
        bus.cmd_valid = 1'($urandom);
        bus.cmd_byte  = 8'($urandom);
        bus.cmd_arg   = 8'($urandom);
      end
      bus.cmd_valid = 1'b0;
      chk("tx_data_hold", bus.tx_data, bytes[idx]);
      bus.tx_done = 1'b1;
      td          = cyc;
      @(posedge clk); #1;
      bus.tx_done = 1'b0;
      njunk = 0;
      forever begin
        item = (script.size() > 0) ? script.pop_front() : pick_item(njunk);
        if (item >= 0 && (item & JV) != 0) begin
          send_rx(8'(item), 1'b1, st);
          exp_scan.push_back(8'(item));
          njunk++;
        end else if (item >= 0 && (item & JI) != 0) begin
          send_rx(8'(item), 1'b0, st);
          njunk++;
        end else break;
      end
      e.is_err = 1'b1;
      e.code   = 2'd0;
      case (item)
        32'hFA: begin
          send_rx(8'hFA, 1'b1, st);
          idx++;
          retries = 0;
          if (idx == n) begin
            e.is_err = 1'b0;
            e.cyc    = st + 1;
            exp_end.push_back(e);
            fin = 1'b1;
          end else exp_tx.push_back(bytes[idx]);
        end
        32'hFE: begin
          send_rx(8'hFE, 1'b1, st);
          if (retries < MAXR) begin
            retries++;
            exp_tx.push_back(bytes[idx]);
          end else begin
            e.code = 2'd1;
            e.cyc  = st + 1;
            exp_end.push_back(e);
            fin = 1'b1;
          end
        end
        32'hFC: begin
          send_rx(8'hFC, 1'b1, st);
          e.code = 2'd2;
          e.cyc  = st + 1;
          exp_end.push_back(e);
          fin = 1'b1;
        end
        default: begin
          // Silence: the wait state is held for exactly TMO cycles.
          e.code = 2'd0;
          e.cyc  = td + TMO + 1;
          exp_end.push_back(e);
          fin = 1'b1;
        end
      endcase
    end
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      if (end_cnt != start_cnt) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    busy = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL cmd_end_wait: got no cmd_done/cmd_err, expected one for cmd %02h", c);
    end
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("end_queue_drained", exp_end.size(), 0);
    exp_tx.delete();
    exp_end.delete();
    script.delete();
  endtask

  task automatic idle_rx();
    int         k;
    logic [7:0] b;
    bit         v;
    longint     st;
    k = int'($urandom_range(0, 2));
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      v = 1'($urandom);
      send_rx(b, v, st);
      if (v) exp_scan.push_back(b);
    end
    @(posedge clk); #1;
    chk("scan_queue_drained", exp_scan.size(), 0);
  endtask

  initial begin
    bit     ok;
    longint st;
    bus.cmd_valid   = 1'b0;
    bus.cmd_byte    = 8'h00;
    bus.cmd_has_arg = 1'b0;
    bus.cmd_arg     = 8'h00;
    bus.tx_done     = 1'b0;
    bus.rx_code     = 8'h00;
    bus.rx_code_new = 1'b0;
    bus.rx_valid    = 1'b0;
    rst_n           = 1'b0;
    #1;
    check_reset("por");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    td_delay = 10;
    script = '{32'hFA};
    run_cmd(8'hF4, 1'b0, 8'h00);

    td_delay = 0;
    script = '{32'hFA, 32'hFA};
    run_cmd(8'hED, 1'b1, 8'h07);

    script = '{32'hFE, 32'hFE, 32'hFE};
    run_cmd(8'hED, 1'b1, 8'h02);

    script = '{IT_NONE};
    run_cmd(8'hF4, 1'b0, 8'h00);

    script = '{JV | 32'h1C, JI | 32'hFA, 32'hFA};
    run_cmd(8'hF4, 1'b0, 8'h00);
    chk("forward_1c_drained", exp_scan.size(), 0);

    // Reset in the middle of a transmit wait.
    accept(8'hF3, 1'b1, 8'h20, ok);
    wait_tx_start(ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    busy = 1'b0;
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_rx(8'h5A, 1'b1, st);
    exp_scan.push_back(8'h5A);
    script = '{32'hFA};
    run_cmd(8'hF4, 1'b0, 8'h00);

    for (int t = 0; t < 40; t++) begin
      idle_rx();
      run_cmd(8'($urandom), 1'($urandom), 8'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_scan_drained", exp_scan.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_cmd_ctrl.md
Name: ps2_cmd_ctrl

Overview:
Host-side command sequencer for the PS/2 keyboard link. Accepts a command byte plus an optional argument byte (e.g. 0xED + LED mask) and drives the PS/2 transmit engine one byte at a time. After each byte it waits for the keyboard's ACK (0xFA), resend request (0xFE) or error (0xFC) on the receive path, with retry and timeout handling. Receive codes it does not consume are forwarded unchanged to the scan-code consumer.

Parameters:
TIMEOUT_CYCLES, 1000000, clk cycles allowed between tx_done and a response byte (20 ms at 50 MHz)
MAX_RETRY, 3, resends allowed per byte before the command is aborted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready
cmd_byte  in  8  command byte
cmd_has_arg  in  1  a second byte follows the command
cmd_arg  in  8  argument byte
tx_start  out  1  one-cycle pulse; transmit engine starts sending tx_data
tx_data  out  8  byte to transmit; held stable from tx_start to tx_done
tx_done  in  1  one-cycle pulse; byte fully shifted out
rx_code  in  8  received byte from the PS/2 receiver
rx_code_new  in  1  one-cycle strobe; rx_code is fresh
rx_valid  in  1  receiver framing/parity ok
scan_code  out  8  forwarded keyboard byte
scan_new  out  1  one-cycle strobe for scan_code
cmd_done  out  1  one-cycle pulse; command fully acknowledged
cmd_err  out  1  one-cycle pulse; command aborted
err_code  out  2  0 timeout, 1 retries exhausted, 2 keyboard 0xFC, 3 reserved; held until the next accept

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE; cmd_ready=1 (IDLE); tx_start=0, tx_data=0, scan_code=0, scan_new=0, cmd_done=0, cmd_err=0, err_code=0; retry and timeout counters cleared; latched cmd/arg cleared.
- FSM states: IDLE, SEND, WAIT_TX, WAIT_RSP, DONE, ERR. The phase bit (CMD or ARG) selects the byte.
- IDLE: on accept, latch cmd_byte, cmd_has_arg and cmd_arg, set phase=CMD, retry=0, and go to SEND next cycle.
- SEND: assert tx_start for exactly one cycle with tx_data = latched byte for the phase. Go to WAIT_TX.
- WAIT_TX: wait for tx_done (no timeout). On tx_done, clear the timeout counter and go to WAIT_RSP.
- WAIT_RSP: the timeout counter increments each cycle, saturating at TIMEOUT_CYCLES. Width is $clog2(TIMEOUT_CYCLES+1).
  - On rx_code_new & rx_valid & rx_code==0xFA:
    - If phase=CMD and has_arg, set phase=ARG, retry=0, and go to SEND.
    - Otherwise go to DONE.
  - On 0xFE: if retry<MAX_RETRY, increment retry and go to SEND (same byte). Otherwise go to ERR with err_code=1.
  - On 0xFC: go to ERR with err_code=2.
  - On any other valid byte: forward it (scan_new) and stay in WAIT_RSP. The timeout counter is not cleared.
  - A byte with rx_valid low is dropped silently.
  - When the counter reaches TIMEOUT_CYCLES: go to ERR with err_code=0.
  - If a response and the timeout occur in the same cycle, the response wins.
- DONE: cmd_done pulses one cycle, then IDLE. ERR: cmd_err pulses one cycle, then IDLE.
- Forwarding: in every state except the WAIT_RSP-consumed cases, rx_code_new & rx_valid produces scan_code<=rx_code and scan_new=1 on the next cycle (1-cycle latency). Invalid bytes are never forwarded.
- cmd_valid while not IDLE has no effect (cmd_ready low).
- Reset mid-command abandons it; tx_start is never re-pulsed after reset.

Optional Feature:
PS2_CMD_INIT_EN.
- Defined: after reset the FSM enters INIT instead of IDLE and issues the internal command 0xFF (reset, no arg) through the normal SEND/WAIT path, with cmd_ready=0.
  - After ACK, the FSM waits in INIT_BAT for 0xAA (BAT pass), sharing the same TIMEOUT_CYCLES rule.
  - 0xAA goes to IDLE without a cmd_done pulse. 0xFC, or a timeout, pulses cmd_err with err_code=2 or 0 respectively, then goes to IDLE.
- Undefined: the FSM resets directly to IDLE; the INIT states are absent.

Decomposition:
Package ps2_pkg:
- state enum typedef
- err_code enum
- constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ERR=8'hFC, PS2_BAT_OK=8'hAA, PS2_CMD_RESET=8'hFF

Sub-module ps2_rsp_timer: loadable saturating timeout counter with a clear input and an expired output.

Test Plan (TIMEOUT_CYCLES=50, MAX_RETRY=2):
- cmd 0xF4, no arg; tx_done 10 cycles after tx_start; rx 0xFA 5 cycles later -> exactly one tx_start with tx_data=0xF4; cmd_done one cycle after the FA cycle+1; no scan_new.
- cmd 0xED, arg 0x07; FA after each byte -> tx sequence 0xED then 0x07; one cmd_done; cmd_ready low throughout.
- cmd 0xED; respond FE, FE, FE -> three tx_start of 0xED, then cmd_err with err_code=1.
- cmd 0xF4; no response -> cmd_err with err_code=0 exactly 50 cycles after tx_done.
- In WAIT_RSP inject 0x1C (valid), then a byte with rx_valid=0, then FA -> scan_code=0x1C with one scan_new; invalid byte dropped; cmd_done.
- rst low asserted mid-WAIT_TX -> all outputs at reset values immediately; new command accepted normally after release.
